// File: rtl/icb_arb_2m1s_pkg.sv
// Shared types and constants for the two-master ICB arbiter.
// Bus widths, master ID encoding and the command bundle.
package icb_arb_2m1s_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_W      = 32;

  localparam logic ICB_MID_M0 = 1'b0;
  localparam logic ICB_MID_M1 = 1'b1;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  read;
    logic [MEM_W-1:0]      wdata;
    logic [MEM_W/8-1:0]    wmask;
  } icb_cmd_t;

endpackage

// File: rtl/icb_ost_fifo.sv
// Outstanding-owner FIFO: DEPTH x 1-bit master IDs, in-order.
// Ports: push/push_id, pop, head, full, empty; async active-low reset.
module icb_ost_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1))
               ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1))
               ? '0 : rd_ptr_q + AW'(1);
    end
    if (do_push & ~do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop & ~do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/icb_arb_2m1s.sv
// Two-master (m0 debug, m1 core) to one-slave ICB arbiter.
// Ports: m0_icb_*/m1_icb_* masters, s_icb_* slave. ICB_ARB_RR_EN = round-robin.
module icb_arb_2m1s
  import icb_arb_2m1s_pkg::*;
#(
  parameter int OST_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_icb_cmd_valid,
  output logic                  m0_icb_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] m0_icb_cmd_addr,
  input  logic                  m0_icb_cmd_read,
  input  logic [MEM_W-1:0]      m0_icb_cmd_wdata,
  input  logic [MEM_W/8-1:0]    m0_icb_cmd_wmask,
  output logic                  m0_icb_rsp_valid,
  input  logic                  m0_icb_rsp_ready,
  output logic                  m0_icb_rsp_err,
  output logic [MEM_W-1:0]      m0_icb_rsp_rdata,
  input  logic                  m1_icb_cmd_valid,
  output logic                  m1_icb_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] m1_icb_cmd_addr,
  input  logic                  m1_icb_cmd_read,
  input  logic [MEM_W-1:0]      m1_icb_cmd_wdata,
  input  logic [MEM_W/8-1:0]    m1_icb_cmd_wmask,
  output logic                  m1_icb_rsp_valid,
  input  logic                  m1_icb_rsp_ready,
  output logic                  m1_icb_rsp_err,
  output logic [MEM_W-1:0]      m1_icb_rsp_rdata,
  output logic                  s_icb_cmd_valid,
  input  logic                  s_icb_cmd_ready,
  output logic [MEM_ADDR_W-1:0] s_icb_cmd_addr,
  output logic                  s_icb_cmd_read,
  output logic [MEM_W-1:0]      s_icb_cmd_wdata,
  output logic [MEM_W/8-1:0]    s_icb_cmd_wmask,
  input  logic                  s_icb_rsp_valid,
  output logic                  s_icb_rsp_ready,
  input  logic                  s_icb_rsp_err,
  input  logic [MEM_W-1:0]      s_icb_rsp_rdata
);

  icb_cmd_t m0_cmd, m1_cmd, s_cmd;
  logic     sel, sel_valid;
  logic     lock_q, lock_d;
  logic     owner_q, owner_d;
  logic     push, pop, head, full, empty;

  assign m0_cmd = '{m0_icb_cmd_addr, m0_icb_cmd_read,
                    m0_icb_cmd_wdata, m0_icb_cmd_wmask};
  assign m1_cmd = '{m1_icb_cmd_addr, m1_icb_cmd_read,
                    m1_icb_cmd_wdata, m1_icb_cmd_wmask};

`ifdef ICB_ARB_RR_EN
  // Last accepted master; the other one wins the next tie.
  logic rr_q, rr_d;

  assign rr_d = push ? sel : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= ICB_MID_M1;
    else        rr_q <= rr_d;
  end
`endif

  // A presented-but-unaccepted command keeps its grant.
  always_comb begin
    sel = ICB_MID_M0;
    if (lock_q) begin
      sel = owner_q;
    end else if (m0_icb_cmd_valid & m1_icb_cmd_valid) begin
`ifdef ICB_ARB_RR_EN
      sel = (rr_q == ICB_MID_M1) ? ICB_MID_M0 : ICB_MID_M1;
`else
      sel = ICB_MID_M0;
`endif
    end else if (m1_icb_cmd_valid) begin
      sel = ICB_MID_M1;
    end
  end

  assign sel_valid = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign s_cmd     = sel ? m1_cmd : m0_cmd;

  assign s_icb_cmd_valid = sel_valid & ~full;
  assign s_icb_cmd_addr  = s_cmd.addr;
  assign s_icb_cmd_read  = s_cmd.read;
  assign s_icb_cmd_wdata = s_cmd.wdata;
  assign s_icb_cmd_wmask = s_cmd.wmask;

  assign m0_icb_cmd_ready = (sel == ICB_MID_M0)
                          & s_icb_cmd_ready & ~full;
  assign m1_icb_cmd_ready = (sel == ICB_MID_M1)
                          & s_icb_cmd_ready & ~full;

  assign push = s_icb_cmd_valid & s_icb_cmd_ready;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (s_icb_cmd_valid) begin
      lock_d  = ~s_icb_cmd_ready;
      owner_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= ICB_MID_M0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  icb_ost_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // A stray response with nothing outstanding is swallowed.
  assign s_icb_rsp_ready = empty ? s_icb_rsp_valid
                         : (head ? m1_icb_rsp_ready
                                 : m0_icb_rsp_ready);

  assign pop = s_icb_rsp_valid & s_icb_rsp_ready & ~empty;

  assign m0_icb_rsp_valid = s_icb_rsp_valid & ~empty
                          & (head == ICB_MID_M0);
  assign m1_icb_rsp_valid = s_icb_rsp_valid & ~empty
                          & (head == ICB_MID_M1);
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

endmodule

// File: tb/tb_icb_arb_2m1s.sv
// Scoreboard bench for icb_arb_2m1s: directed vectors,
// expected slave commands and master responses checked by a monitor.
module tb_icb_arb_2m1s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready;
  logic [31:0] m0_icb_cmd_addr;
  logic        m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready;
  logic [31:0] m1_icb_cmd_addr;
  logic        m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_ready;
  logic [31:0] s_icb_cmd_addr;
  logic        s_icb_cmd_read;
  logic [31:0] s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;

  always #5 clk = ~clk;

  icb_arb_2m1s #(.OST_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid),
    .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata),
    .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid),
    .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid),
    .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata),
    .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid),
    .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid),
    .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr),
    .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata),
    .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid),
    .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err),
    .s_icb_rsp_rdata(s_icb_rsp_rdata)
  );

`ifdef ICB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        mid;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t r0_q[$];
  rsp_t r1_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  task automatic m_cmd(input bit mid, input bit v,
                       input logic [31:0] a, input bit rd);
    if (mid == 1'b0) begin
      m0_icb_cmd_valid = v; m0_icb_cmd_addr = a;
      m0_icb_cmd_read = rd; m0_icb_cmd_wdata = wd(a);
      m0_icb_cmd_wmask = rd ? 4'h0 : 4'hf;
    end else begin
      m1_icb_cmd_valid = v; m1_icb_cmd_addr = a;
      m1_icb_cmd_read = rd; m1_icb_cmd_wdata = wd(a);
      m1_icb_cmd_wmask = rd ? 4'h0 : 4'hf;
    end
  endtask

  task automatic exp_cmd(input bit mid, input logic [31:0] a,
                         input bit rd);
    cmd_q.push_back('{mid, a, rd, wd(a), rd ? 4'h0 : 4'hf});
  endtask

  task automatic srsp(input bit v, input bit e,
                      input logic [31:0] d);
    s_icb_rsp_valid = v; s_icb_rsp_err = e; s_icb_rsp_rdata = d;
  endtask

  task automatic exp_rsp(input bit mid, input bit e,
                         input logic [31:0] d);
    if (mid == 1'b0) r0_q.push_back('{e, d});
    else             r1_q.push_back('{e, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake.
  cmd_t c;
  rsp_t r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_icb_cmd_valid && s_icb_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", s_icb_cmd_addr, 32'hffff_ffff);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_addr", s_icb_cmd_addr, c.addr);
          chk("cmd_read", 32'(s_icb_cmd_read), 32'(c.rd));
          chk("cmd_wdata", s_icb_cmd_wdata, c.wdata);
          chk("cmd_wmask", 32'(s_icb_cmd_wmask), 32'(c.wmask));
          chk("cmd_m0_rdy", 32'(m0_icb_cmd_ready), 32'(!c.mid));
          chk("cmd_m1_rdy", 32'(m1_icb_cmd_ready), 32'(c.mid));
        end
      end
      if (m0_icb_rsp_valid && m0_icb_rsp_ready) begin
        if (r0_q.size() == 0) begin
          chk("m0_rsp_unexpected", m0_icb_rsp_rdata, 32'hffff_ffff);
        end else begin
          r = r0_q.pop_front();
          chk("m0_rsp_err", 32'(m0_icb_rsp_err), 32'(r.err));
          chk("m0_rsp_rdata", m0_icb_rsp_rdata, r.rdata);
        end
      end
      if (m1_icb_rsp_valid && m1_icb_rsp_ready) begin
        if (r1_q.size() == 0) begin
          chk("m1_rsp_unexpected", m1_icb_rsp_rdata, 32'hffff_ffff);
        end else begin
          r = r1_q.pop_front();
          chk("m1_rsp_err", 32'(m1_icb_rsp_err), 32'(r.err));
          chk("m1_rsp_rdata", m1_icb_rsp_rdata, r.rdata);
        end
      end
    end
  end

  bit w2, lsr;

  initial begin
    rst_n = 1'b0;
    m_cmd(0, 0, 32'h0, 1'b1);
    m_cmd(1, 0, 32'h0, 1'b1);
    m0_icb_rsp_ready = 1'b1;
    m1_icb_rsp_ready = 1'b1;
    s_icb_cmd_ready = 1'b0;
    srsp(0, 0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cmd_valid", 32'(s_icb_cmd_valid), 0);
    chk("rst_s_rsp_ready", 32'(s_icb_rsp_ready), 0);
    chk("rst_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
    chk("rst_m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
    chk("rst_m0_cmd_ready", 32'(m0_icb_cmd_ready), 0);
    step();
    rst_n = 1'b1;
    s_icb_cmd_ready = 1'b1;
    @(negedge clk);
    chk("idle_s_rsp_ready", 32'(s_icb_rsp_ready), 0);
    chk("idle_m1_cmd_ready", 32'(m1_icb_cmd_ready), 0);
    step();

    // Single m1 read
    exp_cmd(1, 32'h1000, 1);
    m_cmd(1, 1, 32'h1000, 1);
    @(negedge clk);
    chk("a_m0_cmd_ready", 32'(m0_icb_cmd_ready), 0);
    step();
    m_cmd(1, 0, 32'h1000, 1);
    srsp(1, 0, 32'hDEAD_BEEF);
    exp_rsp(1, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("a_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
    chk("a_m1_rsp_valid", 32'(m1_icb_rsp_valid), 1);
    step();
    srsp(0, 0, 32'h0);
    step();

    // Ties, full FIFO, push+pop in one cycle
    w2  = RR;
    lsr = !RR;
    exp_cmd(0, 32'h2000, 1);
    m_cmd(0, 1, 32'h2000, 1);
    m_cmd(1, 1, 32'h2100, 0);
    step();
    m_cmd(0, 1, 32'h2004, 1);
    if (RR) exp_cmd(1, 32'h2100, 0);
    else    exp_cmd(0, 32'h2004, 1);
    step();
    m_cmd(w2, 0, 32'h0, 1);
    @(negedge clk);
    chk("b_full_block", 32'(s_icb_cmd_valid), 0);
    step();
    srsp(1, 0, 32'h11);
    exp_rsp(0, 0, 32'h11);
    @(negedge clk);
    chk("b_full_pop_block", 32'(s_icb_cmd_valid), 0);
    step();
    srsp(1, 0, 32'h22);
    exp_rsp(w2, 0, 32'h22);
    if (RR) exp_cmd(0, 32'h2004, 1);
    else    exp_cmd(1, 32'h2100, 0);
    @(negedge clk);
    chk("b_pushpop_valid", 32'(s_icb_cmd_valid), 1);
    step();
    m_cmd(lsr, 0, 32'h0, 1);
    srsp(1, 0, 32'h33);
    exp_rsp(lsr, 0, 32'h33);
    step();
    srsp(0, 0, 32'h0);
    step();

    // Lock: m1 held while m0 requests
    s_icb_cmd_ready = 1'b0;
    exp_cmd(1, 32'h3100, 0);
    m_cmd(1, 1, 32'h3100, 0);
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) m_cmd(0, 1, 32'h3000, 1);
      @(negedge clk);
      chk("c_lock_valid", 32'(s_icb_cmd_valid), 1);
      chk("c_lock_addr", s_icb_cmd_addr, 32'h3100);
      chk("c_lock_m0_rdy", 32'(m0_icb_cmd_ready), 0);
      step();
    end
    s_icb_cmd_ready = 1'b1;
    step();
    m_cmd(1, 0, 32'h0, 1);
    exp_cmd(0, 32'h3000, 1);
    step();
    m_cmd(0, 0, 32'h0, 1);
    srsp(1, 0, 32'h44);
    exp_rsp(1, 0, 32'h44);
    step();
    srsp(1, 0, 32'h55);
    exp_rsp(0, 0, 32'h55);
    step();
    srsp(0, 0, 32'h0);
    step();

    // m0 write then m1 read, error routing, backpressure
    exp_cmd(0, 32'h4000, 0);
    m_cmd(0, 1, 32'h4000, 0);
    step();
    m_cmd(0, 0, 32'h0, 1);
    exp_cmd(1, 32'h4100, 1);
    m_cmd(1, 1, 32'h4100, 1);
    step();
    m_cmd(1, 0, 32'h0, 1);
    m1_icb_rsp_ready = 1'b0;
    srsp(1, 1, 32'hBAD0);
    exp_rsp(0, 1, 32'hBAD0);
    @(negedge clk);
    chk("e_m0_err", 32'(m0_icb_rsp_err), 1);
    chk("e_m1_quiet", 32'(m1_icb_rsp_valid), 0);
    step();
    srsp(1, 0, 32'h66);
    @(negedge clk);
    chk("e_bp_s_rdy", 32'(s_icb_rsp_ready), 0);
    chk("e_bp_m1_valid", 32'(m1_icb_rsp_valid), 1);
    step();
    m1_icb_rsp_ready = 1'b1;
    exp_rsp(1, 0, 32'h66);
    @(negedge clk);
    chk("e_s_rdy", 32'(s_icb_rsp_ready), 1);
    step();
    srsp(0, 0, 32'h0);
    step();

    // Reset with two outstanding, then stray response
    exp_cmd(0, 32'h5000, 1);
    m_cmd(0, 1, 32'h5000, 1);
    step();
    m_cmd(0, 0, 32'h0, 1);
    exp_cmd(1, 32'h5100, 1);
    m_cmd(1, 1, 32'h5100, 1);
    step();
    m_cmd(1, 0, 32'h0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("f_rst_s_rdy", 32'(s_icb_rsp_ready), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("f_post_s_rdy", 32'(s_icb_rsp_ready), 0);
    chk("f_post_m0_valid", 32'(m0_icb_rsp_valid), 0);
    step();
    srsp(1, 0, 32'h99);
    @(negedge clk);
    chk("f_stray_s_rdy", 32'(s_icb_rsp_ready), 1);
    chk("f_stray_m0", 32'(m0_icb_rsp_valid), 0);
    chk("f_stray_m1", 32'(m1_icb_rsp_valid), 0);
    step();
    srsp(0, 0, 32'h0);
    exp_cmd(0, 32'h6000, 1);
    m_cmd(0, 1, 32'h6000, 1);
    step();
    m_cmd(0, 0, 32'h0, 1);
    srsp(1, 0, 32'h77);
    exp_rsp(0, 0, 32'h77);
    step();
    srsp(0, 0, 32'h0);
    step();

    chk("end_cmd_q", cmd_q.size(), 0);
    chk("end_r0_q", r0_q.size(), 0);
    chk("end_r1_q", r1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
